axi_csr_master: RTL and testbench
=================================

# axi_csr_master

Single-outstanding AXI4 initiator that turns a simple command/response interface into one-beat AXI4 read or write transactions toward CSR-style responders such as the per-core reset-address/PC register block. It sits on the host/debug side of the CSR fabric, so boot firmware or a debug bridge can program core reset addresses and sample PCs without speaking AXI. Each transaction carries its own rolling ID. Every response is checked for ID and RLAST consistency before it is returned to the requester.

## Interface
- AXI_ID_WIDTH, 8, width of AWID/ARID/BID/RID and of the internal ID counter
- AXI_ADDR_WIDTH, 12, byte address width
- AXI_DATA_WIDTH, 32, data width; must be 32 or 64
- aclk  in  1  clock
- arstn  in  1  reset, asynchronous, active-low
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  AXI_ADDR_WIDTH  byte address
- cmd_wdata / cmd_wstrb  in  AXI_DATA_WIDTH / AXI_DATA_WIDTH/8  write data and strobes
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake
- rsp_rdata  out  AXI_DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  BRESP or RRESP as received
- rsp_err  out  1  ID mismatch or RLAST=0 on the returned beat
- axi_aw* / axi_w* / axi_b* / axi_ar* / axi_r*  AXI4 master side  full AXI4 port set, widths per parameters (LEN 8, SIZE 3, BURST 2, CACHE 4, LOCK 1, PROT 3, QOS 4, RESP 2)

## Operation
- Constant outputs:
  - AxLEN = 0, AxBURST = INCR (2'b01), AxSIZE = log2(AXI_DATA_WIDTH/8).
  - AxCACHE, AxLOCK, AxPROT, AxQOS = 0.
  - WLAST = 1 whenever WVALID is high.
- Address: AxADDR = cmd_addr with its low log2(AXI_DATA_WIDTH/8) bits forced to 0. The remaining bits are registered at command accept.
- ID: id_cnt resets to 0 and increments by 1 (mod 2^AXI_ID_WIDTH) on every command accept. The issued ID equals id_cnt before the increment.
- FSM states:
  - IDLE: cmd_ready = 1. cmd_valid with cmd_write=1 goes to WR_ADDR; cmd_valid with cmd_write=0 goes to RD_ADDR. Command fields are latched.
  - WR_ADDR: AWVALID and WVALID are both asserted. Each channel drops independently on its own handshake, tracked by aw_done and w_done. Go to WR_RESP when both are done, including the same cycle.
  - WR_RESP: BREADY = 1. On the B handshake, latch BRESP, set err = (BID != issued ID), and go to RSP.
  - RD_ADDR: ARVALID = 1. On the AR handshake go to RD_RESP.
  - RD_RESP: RREADY = 1. On the R handshake, latch RDATA and RRESP, set err = (RID != issued ID) | ~RLAST, and go to RSP.
  - RSP: rsp_valid = 1 and outputs hold stable. On rsp_ready go to IDLE.
- No new command is accepted until the response handshake completes, so there is at most one transaction outstanding.
- All AXI valid/ready outputs and rsp_* are registered; none depends combinationally on an input.

## Timing
- Reset values: cmd_ready = 1, id_cnt = 0, state = IDLE; every other output = 0. AxSIZE and AxBURST are the exception and drive their constant values.
- Reset mid-transaction: all valids drop immediately and the FSM returns to IDLE with no response. The responder shares arstn.
- Command accepted at cycle N: AWVALID/WVALID or ARVALID go high at N+1.
- With a zero-wait responder:
  - Write: BVALID at N+2, rsp_valid at N+3.
  - Read: RVALID at N+2, rsp_valid at N+3.
- AWVALID, WVALID and ARVALID, once high, hold with stable payload until their handshake (AXI rule).
- AW accepted several cycles before W, or W before AW: both orders are legal. State stays WR_ADDR until both are done.
- rsp_ready held low: rsp_valid and rsp_* hold indefinitely. cmd_ready stays 0.
- cmd_ready rises in the cycle after the rsp handshake, so back-to-back commands are spaced at least 4 cycles.

## Structure
- Shared package axi_csr_pkg holds:
  - State enum (IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP, RSP).
  - AXI constants: BURST_INCR, RESP_OKAY/EXOKAY/SLVERR/DECERR.
  - Register-offset constants, shared with the CSR responder.
- Single flat module. No sub-module is natural because the datapath is one latched command plus one response register.

## Test plan
- Write 0x0000_1000 to addr 0x000 against a zero-wait responder -> AW/W at N+1 with AWID=0, WLAST=1, WSTRB=0xF; rsp_valid at N+3 with rsp_resp=0, rsp_err=0.
- Read addr 0x00B -> ARADDR=0x008, ARID=1, ARLEN=0, ARSIZE=2; RDATA 0xDEAD_BEEF returns rsp_rdata=0xDEAD_BEEF, rsp_err=0.
- Write with AWREADY delayed 5 cycles and WREADY immediate, then the reverse -> AWVALID/WVALID are each stable until their own handshake; exactly one rsp per command.
- Responder returns RID off by one, or RLAST=0 -> rsp_err=1 with rsp_rdata still latched. BRESP=2'b10 -> rsp_resp=2'b10.
- Issue 257 commands with AXI_ID_WIDTH=8 -> IDs 0..255 then wrap to 0; hold rsp_ready low for 10 cycles -> rsp payload stable and cmd_ready=0 throughout.
- Assert arstn low while in WR_ADDR -> AWVALID and WVALID go to 0 asynchronously; after release, cmd_ready=1 and the next command uses ID 0.

Source files
------------

// File: rtl/axi_csr_pkg.sv
// -----------------------------------------------------------------------------
// axi_csr_pkg
// Shared definitions for the CSR fabric host side and its CSR responders:
//   - FSM state encoding of the single-outstanding AXI4 CSR master
//   - AXI4 burst / response encodings
//   - register offsets of the per-core reset-address / PC register block
//   - helper to derive AxSIZE from the data-bus width
// -----------------------------------------------------------------------------
package axi_csr_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_ADDR = 3'd1,
      WR_RESP = 3'd2,
      RD_ADDR = 3'd3,
      RD_RESP = 3'd4,
      RSP     = 3'd5
   } csr_state_e;

   localparam logic [1:0] BURST_INCR  = 2'b01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Per-core register block layout (byte offsets, one block per core).
   localparam logic [11:0] CSR_CORE_STRIDE  = 12'h010;
   localparam logic [11:0] CSR_RST_ADDR_OFS = 12'h000;
   localparam logic [11:0] CSR_PC_OFS       = 12'h008;

   // AxSIZE encoding for a full-width beat: log2(bytes per beat).
   function automatic logic [2:0] axsize_of(input int data_w);
      return 3'($clog2(data_w / 8));
   endfunction

endpackage

// File: rtl/axi_csr_master.sv
// -----------------------------------------------------------------------------
// axi_csr_master
// Single-outstanding AXI4 initiator. Converts a simple command/response
// interface into one-beat AXI4 reads or writes toward CSR responders.
// Every transaction carries a rolling ID; returned BID/RID and RLAST are
// checked and any inconsistency is flagged on rsp_err.
//
// Ports:
//   aclk, arstn                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_write, cmd_addr         1 = write / 0 = read, byte address
//   cmd_wdata, cmd_wstrb        write data and byte strobes
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata, rsp_resp         read data (0 for writes), BRESP/RRESP
//   rsp_err                     ID mismatch or missing RLAST
//   axi_aw*/w*/b*/ar*/r*        AXI4 master port
// -----------------------------------------------------------------------------
module axi_csr_master
   import axi_csr_pkg::*;
#(
   parameter int AXI_ID_WIDTH   = 8,
   parameter int AXI_ADDR_WIDTH = 12,
   parameter int AXI_DATA_WIDTH = 32   // 32 or 64
) (
   input  logic                          aclk,
   input  logic                          arstn,
   // command side
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_write,
   input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [AXI_DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
   // response side
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                    rsp_resp,
   output logic                          rsp_err,
   // AXI write address
   output logic [AXI_ID_WIDTH-1:0]       axi_awid,
   output logic [AXI_ADDR_WIDTH-1:0]     axi_awaddr,
   output logic [7:0]                    axi_awlen,
   output logic [2:0]                    axi_awsize,
   output logic [1:0]                    axi_awburst,
   output logic                          axi_awlock,
   output logic [3:0]                    axi_awcache,
   output logic [2:0]                    axi_awprot,
   output logic [3:0]                    axi_awqos,
   output logic                          axi_awvalid,
   input  logic                          axi_awready,
   // AXI write data
   output logic [AXI_DATA_WIDTH-1:0]     axi_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0]   axi_wstrb,
   output logic                          axi_wlast,
   output logic                          axi_wvalid,
   input  logic                          axi_wready,
   // AXI write response
   input  logic [AXI_ID_WIDTH-1:0]       axi_bid,
   input  logic [1:0]                    axi_bresp,
   input  logic                          axi_bvalid,
   output logic                          axi_bready,
   // AXI read address
   output logic [AXI_ID_WIDTH-1:0]       axi_arid,
   output logic [AXI_ADDR_WIDTH-1:0]     axi_araddr,
   output logic [7:0]                    axi_arlen,
   output logic [2:0]                    axi_arsize,
   output logic [1:0]                    axi_arburst,
   output logic                          axi_arlock,
   output logic [3:0]                    axi_arcache,
   output logic [2:0]                    axi_arprot,
   output logic [3:0]                    axi_arqos,
   output logic                          axi_arvalid,
   input  logic                          axi_arready,
   // AXI read data
   input  logic [AXI_ID_WIDTH-1:0]       axi_rid,
   input  logic [AXI_DATA_WIDTH-1:0]     axi_rdata,
   input  logic [1:0]                    axi_rresp,
   input  logic                          axi_rlast,
   input  logic                          axi_rvalid,
   output logic                          axi_rready
);

   localparam logic [2:0] AXSIZE = axsize_of(AXI_DATA_WIDTH);
   localparam int         LSB    = $clog2(AXI_DATA_WIDTH / 8);
   // Clears the byte-offset bits so every access is bus-width aligned.
   localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK =
      ~(AXI_ADDR_WIDTH'((1 << LSB) - 1));

   csr_state_e                  state;
   logic [AXI_ID_WIDTH-1:0]     id_cnt;
   logic [AXI_ID_WIDTH-1:0]     id_q;
   logic [AXI_ADDR_WIDTH-1:0]   addr_q;
   logic [AXI_DATA_WIDTH-1:0]   wdata_q;
   logic [AXI_DATA_WIDTH/8-1:0] wstrb_q;
   logic                        aw_done;
   logic                        w_done;
   logic                        aw_hs;
   logic                        w_hs;

   assign aw_hs = axi_awvalid && axi_awready;
   assign w_hs  = axi_wvalid  && axi_wready;

   // Single-beat INCR, normal/non-cacheable/unprivileged access.
   assign axi_awlen   = '0;
   assign axi_awsize  = AXSIZE;
   assign axi_awburst = BURST_INCR;
   assign axi_awlock  = 1'b0;
   assign axi_awcache = '0;
   assign axi_awprot  = '0;
   assign axi_awqos   = '0;
   assign axi_arlen   = '0;
   assign axi_arsize  = AXSIZE;
   assign axi_arburst = BURST_INCR;
   assign axi_arlock  = 1'b0;
   assign axi_arcache = '0;
   assign axi_arprot  = '0;
   assign axi_arqos   = '0;

   // Address/ID/data come straight from the latched command, so payload is
   // stable for as long as the corresponding valid is held.
   assign axi_awid   = id_q;
   assign axi_arid   = id_q;
   assign axi_awaddr = addr_q;
   assign axi_araddr = addr_q;
   assign axi_wdata  = wdata_q;
   assign axi_wstrb  = wstrb_q;
   // Every write is one beat, so the only beat is always the last one.
   assign axi_wlast  = axi_wvalid;

   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         state       <= IDLE;
         cmd_ready   <= 1'b1;
         id_cnt      <= '0;
         id_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         axi_awvalid <= 1'b0;
         axi_wvalid  <= 1'b0;
         axi_bready  <= 1'b0;
         axi_arvalid <= 1'b0;
         axi_rready  <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_resp    <= RESP_OKAY;
         rsp_err     <= 1'b0;
      end else begin
         case (state)
            // ---- command accept ----
            IDLE: begin
               if (cmd_valid) begin
                  cmd_ready <= 1'b0;
                  id_q      <= id_cnt;
                  id_cnt    <= id_cnt + 1'b1;
                  addr_q    <= cmd_addr & ADDR_MASK;
                  wdata_q   <= cmd_wdata;
                  wstrb_q   <= cmd_wstrb;
                  aw_done   <= 1'b0;
                  w_done    <= 1'b0;
                  if (cmd_write) begin
                     axi_awvalid <= 1'b1;
                     axi_wvalid  <= 1'b1;
                     state       <= WR_ADDR;
                  end else begin
                     axi_arvalid <= 1'b1;
                     state       <= RD_ADDR;
                  end
               end
            end
            // ---- write address / data issue ----
            WR_ADDR: begin
               // AW and W complete independently, in either order.
               if (aw_hs) begin
                  axi_awvalid <= 1'b0;
                  aw_done     <= 1'b1;
               end
               if (w_hs) begin
                  axi_wvalid <= 1'b0;
                  w_done     <= 1'b1;
               end
               if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                  axi_bready <= 1'b1;
                  state      <= WR_RESP;
               end
            end
            // ---- write response ----
            WR_RESP: begin
               if (axi_bvalid) begin
                  axi_bready <= 1'b0;
                  rsp_rdata  <= '0;
                  rsp_resp   <= axi_bresp;
                  rsp_err    <= (axi_bid != id_q);
                  rsp_valid  <= 1'b1;
                  state      <= RSP;
               end
            end
            // ---- read address issue ----
            RD_ADDR: begin
               if (axi_arready) begin
                  axi_arvalid <= 1'b0;
                  axi_rready  <= 1'b1;
                  state       <= RD_RESP;
               end
            end
            // ---- read data ----
            RD_RESP: begin
               if (axi_rvalid) begin
                  axi_rready <= 1'b0;
                  rsp_rdata  <= axi_rdata;
                  rsp_resp   <= axi_rresp;
                  rsp_err    <= (axi_rid != id_q) || !axi_rlast;
                  rsp_valid  <= 1'b1;
                  state      <= RSP;
               end
            end
            // ---- response to requester ----
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_csr_master.sv
// -----------------------------------------------------------------------------
// tb_axi_csr_master
// Drives commands into axi_csr_master, plays a configurable AXI responder
// (per-channel ready delays, response delay, ID / RLAST faults, BRESP/RRESP)
// and compares every observable against a transaction-level model: issued ID
// is a wrapping count of accepted commands, addresses are bus-aligned, and the
// response carries the responder's data/resp plus the expected error flag.
// -----------------------------------------------------------------------------
module tb_axi_csr_master;
   import axi_csr_pkg::*;

   logic        aclk = 1'b0;
   logic        arstn = 1'b0;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [11:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [7:0]  axi_awid, axi_awlen, axi_bid, axi_arid, axi_arlen, axi_rid;
   logic [11:0] axi_awaddr, axi_araddr;
   logic [2:0]  axi_awsize, axi_awprot, axi_arsize, axi_arprot;
   logic [1:0]  axi_awburst, axi_arburst, axi_bresp, axi_rresp;
   logic        axi_awlock, axi_arlock;
   logic [3:0]  axi_awcache, axi_awqos, axi_arcache, axi_arqos, axi_wstrb;
   logic        axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
   logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready;
   logic        axi_rlast, axi_rvalid, axi_rready;
   logic [31:0] axi_wdata, axi_rdata;

   int          n_chk = 0;
   int          n_pass = 0;
   logic [7:0]  id_model;   // ID the next accepted command must carry

   axi_csr_master #(.AXI_ID_WIDTH(8), .AXI_ADDR_WIDTH(12), .AXI_DATA_WIDTH(32)) dut (
      .aclk(aclk), .arstn(arstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_err(rsp_err),
      .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
      .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
      .axi_awcache(axi_awcache), .axi_awprot(axi_awprot), .axi_awqos(axi_awqos),
      .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
      .axi_bready(axi_bready),
      .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
      .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
      .axi_arcache(axi_arcache), .axi_arprot(axi_arprot), .axi_arqos(axi_arqos),
      .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
      .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   // One complete command: issue, play responder, check response, handshake.
   task automatic run_txn(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [31:0] rd,
                          input int a_dly, input int w_dly, input int b_dly,
                          input logic [1:0] resp, input bit id_bad, input bit last_bad,
                          input int hold);
      logic [7:0]  eid;
      logic [11:0] eaddr;
      logic [31:0] erdata;
      logic        eerr;
      bit          a_done, w_done;
      int          t, cyc;
      eid    = id_model;
      eaddr  = {addr[11:2], 2'b00};
      erdata = wr ? 32'h0 : rd;
      eerr   = id_bad || (!wr && last_bad);

      @(negedge aclk);
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
      @(negedge aclk);
      cyc = 1;
      cmd_valid = 0; cmd_wdata = $urandom; cmd_addr = 12'($urandom);
      id_model = id_model + 8'd1;
      chk("cmd_ready_busy", cmd_ready, 0);

      a_done = 0; w_done = !wr; t = 0;
      while (!(a_done && w_done)) begin
         if (t > 100) begin chk("addr_phase_timeout", 0, 1); return; end
         if (wr) begin
            chk("awvalid", axi_awvalid, !a_done);
            chk("wvalid", axi_wvalid, !w_done);
            if (!a_done) begin
               chk("awaddr", axi_awaddr, eaddr);
               chk("awid", axi_awid, eid);
               chk("aw_const", {axi_awlen, axi_awsize, axi_awburst, axi_awcache,
                                axi_awlock, axi_awprot, axi_awqos},
                   {8'h0, 3'd2, 2'b01, 4'h0, 1'b0, 3'h0, 4'h0});
            end
            if (!w_done) begin
               chk("wdata", axi_wdata, wd);
               chk("wstrb", axi_wstrb, ws);
               chk("wlast", axi_wlast, 1);
            end
            axi_awready = !a_done && (t >= a_dly);
            axi_wready  = !w_done && (t >= w_dly);
         end else begin
            chk("arvalid", axi_arvalid, !a_done);
            chk("araddr", axi_araddr, eaddr);
            chk("arid", axi_arid, eid);
            chk("ar_const", {axi_arlen, axi_arsize, axi_arburst, axi_arcache,
                             axi_arlock, axi_arprot, axi_arqos},
                {8'h0, 3'd2, 2'b01, 4'h0, 1'b0, 3'h0, 4'h0});
            axi_arready = (t >= a_dly);
         end
         @(negedge aclk);
         cyc++;
         if (t >= a_dly) a_done = 1;
         if (wr && t >= w_dly) w_done = 1;
         axi_awready = 0; axi_wready = 0; axi_arready = 0;
         t++;
      end

      if (wr) chk("no_awvalid_resp", {axi_awvalid, axi_wvalid}, 0);
      else    chk("no_arvalid_resp", axi_arvalid, 0);
      for (int i = 0; i < b_dly; i++) begin
         chk("resp_ready_wait", wr ? axi_bready : axi_rready, 1);
         @(negedge aclk);
         cyc++;
      end
      if (wr) begin
         axi_bvalid = 1; axi_bid = eid + 8'(id_bad); axi_bresp = resp;
         chk("bready", axi_bready, 1);
      end else begin
         axi_rvalid = 1; axi_rid = eid + 8'(id_bad); axi_rdata = rd;
         axi_rresp = resp; axi_rlast = !last_bad;
         chk("rready", axi_rready, 1);
      end
      chk("rsp_valid_early", rsp_valid, 0);
      @(negedge aclk);
      cyc++;
      axi_bvalid = 0; axi_rvalid = 0; axi_rlast = 0;
      axi_bid = $urandom; axi_rid = $urandom; axi_rdata = $urandom;
      axi_bresp = 2'($urandom); axi_rresp = 2'($urandom);
      chk("rsp_valid", rsp_valid, 1);
      chk("resp_ready_drop", {axi_bready, axi_rready}, 0);
      if (a_dly == 0 && w_dly == 0 && b_dly == 0) chk("rsp_latency", cyc, 3);

      for (int h = 0; h < hold; h++) begin
         chk("hold_rsp_valid", rsp_valid, 1);
         chk("hold_payload", {rsp_rdata, rsp_resp, rsp_err}, {erdata, resp, eerr});
         chk("hold_cmd_ready", cmd_ready, 0);
         @(negedge aclk);
      end
      chk("rsp_rdata", rsp_rdata, erdata);
      chk("rsp_resp", rsp_resp, resp);
      chk("rsp_err", rsp_err, eerr);
      rsp_ready = 1;
      @(negedge aclk);
      rsp_ready = 0;
      chk("rsp_once", rsp_valid, 0);
      chk("cmd_ready_back", cmd_ready, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
      rsp_ready = 0;
      axi_awready = 0; axi_wready = 0; axi_arready = 0;
      axi_bvalid = 0; axi_bid = 0; axi_bresp = 0;
      axi_rvalid = 0; axi_rid = 0; axi_rdata = 0; axi_rresp = 0; axi_rlast = 0;
      id_model = 0;
      arstn = 0;
      repeat (3) @(negedge aclk);

      // Reset state
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_valids", {axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready, axi_wlast}, 0);
      chk("rst_rsp", {rsp_valid, rsp_rdata, rsp_resp, rsp_err}, 0);
      chk("rst_ids_addr", {axi_awid, axi_arid, axi_awaddr, axi_araddr}, 0);
      chk("rst_wdata", {axi_wdata, axi_wstrb}, 0);
      chk("rst_aw_const", {axi_awlen, axi_awsize, axi_awburst, axi_awcache,
                           axi_awlock, axi_awprot, axi_awqos},
          {8'h0, 3'd2, 2'b01, 4'h0, 1'b0, 3'h0, 4'h0});
      chk("rst_ar_const", {axi_arlen, axi_arsize, axi_arburst, axi_arcache,
                           axi_arlock, axi_arprot, axi_arqos},
          {8'h0, 3'd2, 2'b01, 4'h0, 1'b0, 3'h0, 4'h0});
      arstn = 1;

      // Directed: basic write, misaligned read, channel ordering
      run_txn(1, 12'h000, 32'h0000_1000, 4'hF, 0, 0, 0, 0, RESP_OKAY, 0, 0, 0);
      run_txn(0, 12'h00B, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, RESP_OKAY, 0, 0, 0);
      run_txn(1, CSR_CORE_STRIDE + CSR_RST_ADDR_OFS, 32'h8000_0000, 4'hF, 0, 5, 0, 0, RESP_OKAY, 0, 0, 0);
      run_txn(1, CSR_CORE_STRIDE + CSR_PC_OFS + 12'd1, 32'h1234_5678, 4'h3, 0, 0, 5, 0, RESP_OKAY, 0, 0, 0);
      // Directed: faults and error responses
      run_txn(0, CSR_PC_OFS, 0, 0, 32'hCAFE_F00D, 0, 0, 0, RESP_OKAY, 1, 0, 0);
      run_txn(0, CSR_PC_OFS, 0, 0, 32'h0BAD_0BAD, 0, 0, 0, RESP_OKAY, 0, 1, 0);
      run_txn(1, 12'h020, 32'h5555_AAAA, 4'hC, 0, 0, 0, 0, RESP_SLVERR, 0, 0, 0);
      run_txn(1, 12'h024, 32'hA5A5_5A5A, 4'hF, 0, 1, 2, 3, RESP_DECERR, 1, 0, 0);
      run_txn(0, 12'h030, 0, 0, 32'h0F0F_0F0F, 2, 0, 2, RESP_EXOKAY, 0, 0, 10);
      run_txn(1, 12'h034, 32'hFFFF_0000, 4'h1, 0, 0, 0, 0, RESP_OKAY, 0, 0, 10);

      // Randomized: enough commands to wrap the 8-bit ID counter
      for (int n = 0; n < 260; n++) begin
         run_txn(bit'($urandom_range(0, 1)), 12'($urandom), $urandom, 4'($urandom),
                 $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                 2'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 2));
      end

      // Reset asserted while stuck in the write address phase
      @(negedge aclk);
      cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h040; cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
      @(negedge aclk);
      cmd_valid = 0;
      chk("pre_rst_valids", {axi_awvalid, axi_wvalid}, 2'b11);
      @(negedge aclk);
      #2 arstn = 0;
      #1;
      chk("async_rst_valids", {axi_awvalid, axi_wvalid, axi_wlast}, 0);
      chk("async_rst_cmd_ready", cmd_ready, 1);
      chk("async_rst_rsp_valid", rsp_valid, 0);
      @(negedge aclk);
      arstn = 1;
      id_model = 0;
      run_txn(1, 12'h044, 32'h7777_7777, 4'hF, 0, 0, 0, 0, RESP_OKAY, 0, 0, 0);
      run_txn(0, 12'h048, 0, 0, 32'h3C3C_3C3C, 0, 0, 0, RESP_OKAY, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
